bram_mem_bridge: RTL and testbench
==================================

BRAM_MEM_BRIDGE -- requirements
Module: bram_mem_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base of the 4 KiB RAM window; bits [11:0] are zero.
REQ-002 SHALL have parameter CNT_W, default 16, width of the access statistics counters.
REQ-003 clka  in  1  single clock; all state changes on its rising edge.
REQ-004 rsta  in  1  reset, synchronous, active-high.
REQ-005 mem_valid  in  1  CPU request valid (picorv32 native bus).
REQ-006 mem_addr  in  32  CPU byte address; bits [1:0] ignored.
REQ-007 mem_wdata  in  32  CPU write data.
REQ-008 mem_wstrb  in  4  byte strobes; 4'b0000 = read, nonzero = write.
REQ-009 mem_ready  out  1  one-cycle completion pulse.
REQ-010 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-011 sel  out  1  combinational window hit = mem_valid && (mem_addr[31:12] == BASE_ADDR[31:12]).
REQ-012 bram_addra  out  10  RAM word address = mem_addr[11:2], registered.
REQ-013 bram_cea  out  1  RAM clock enable, registered.
REQ-014 bram_dia  out  32  RAM write data, registered.
REQ-015 bram_wea  out  4  RAM byte write enables, registered.
REQ-016 bram_rsta  out  1  RAM output reset, equal to rsta.
REQ-017 bram_doa  in  32  RAM read data, valid after the edge following the cea=1 edge (unregistered RAM output).
REQ-018 rd_count, wr_count  out  CNT_W each  completed read/write counts.

Function
REQ-019 SHALL implement states IDLE, ACCESS, CAPTURE, DONE.
REQ-020 IDLE: on an edge with sel=1, register bram_addra=mem_addr[11:2], bram_dia=mem_wdata, bram_wea=mem_wstrb, bram_cea=1, latch the read/write kind; go to ACCESS.
REQ-021 IDLE with sel=0: no RAM activity, stay in IDLE; out-of-window requests are never acknowledged by this block.
REQ-022 ACCESS: RAM performs the operation at this edge; bram_cea, bram_wea go to 0; read goes to CAPTURE; write sets mem_ready=1, increments wr_count, goes to DONE.
REQ-023 CAPTURE: mem_rdata <= bram_doa, mem_ready=1, increment rd_count, go to DONE.
REQ-024 DONE: mem_ready=0 at the next edge, go to IDLE; no new request is accepted in DONE, even when mem_valid is still high.
REQ-025 Latency from the accepting edge: read ack 3 cycles (mem_ready high in cycle 3), write ack 2 cycles; back-to-back throughput is 1 access per 4 (read) or 3 (write) cycles.
REQ-026 mem_rdata SHALL hold its last captured value until the next read capture; writes do not change it.
REQ-027 Request inputs are sampled only in IDLE; if mem_valid deasserts or inputs change after acceptance, the accepted access still completes and mem_ready still pulses.
REQ-028 Partial writes: only bytes with mem_wstrb[i]=1 change, via bram_wea[i].
REQ-029 Counters SHALL saturate at all-ones and not wrap.
REQ-030 bram_cea SHALL never be high for more than one consecutive cycle per access.

Reset
REQ-031 rsta=1 at an edge forces state IDLE, mem_ready=0, mem_rdata=0, bram_addra=0, bram_cea=0, bram_dia=0, bram_wea=0, rd_count=0, wr_count=0, with priority over all other activity.
REQ-032 rsta asserted mid-transaction aborts it with no mem_ready pulse; if asserted in ACCESS the RAM write at that edge is permitted, and the bench SHALL NOT check that RAM content.

Verification
REQ-033 Write 0xDEADBEEF to BASE_ADDR+0x10, wstrb=4'hF -> bram_addra=4, bram_wea=4'hF for one cycle, mem_ready pulse 2 cycles after acceptance, wr_count=1.
REQ-034 Read BASE_ADDR+0x10 after REQ-033 -> mem_rdata=0xDEADBEEF with a one-cycle mem_ready pulse 3 cycles after acceptance, rd_count=1.
REQ-035 Write 0x000000AA with wstrb=4'b0001 to the same word, then read it -> 0xDEADBEAA.
REQ-036 Request to BASE_ADDR+0x1000 -> sel=0, bram_cea stays 0, no mem_ready, counters unchanged.
REQ-037 mem_valid held high across 3 back-to-back reads -> exactly 3 mem_ready pulses, each separated by 3 low cycles; no access accepted in DONE.
REQ-038 rsta pulsed in CAPTURE -> no mem_ready, mem_rdata=0, IDLE next cycle; the following read completes normally.

Source files
------------

// File: rtl/bram_mem_bridge_if.sv
// CPU-side native memory bus (picorv32 style) between a core and the BRAM bridge.
// The core drives the request; the bridge returns a one-cycle ready pulse.
interface bram_mem_bridge_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/bram_mem_bridge.sv
// Bridges a picorv32 native bus onto a single-port BRAM with an unregistered output.
// One access in flight; saturating read/write completion counters.
module bram_mem_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clka,
    input  logic             rsta,
    bram_mem_bridge_if.slave bus,
    output logic             sel,
    output logic [9:0]       bram_addra,
    output logic             bram_cea,
    output logic [31:0]      bram_dia,
    output logic [3:0]       bram_wea,
    output logic             bram_rsta,
    input  logic [31:0]      bram_doa,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       addr_q, addr_d;
    logic [31:0]      dia_q, dia_d;
    logic [3:0]       wea_q, wea_d;
    logic             cea_q, cea_d;
    logic             is_rd_q, is_rd_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    assign sel = bus.mem_valid
              && (bus.mem_addr[31:12] == BASE_ADDR[31:12]);

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            dia_q    <= '0;
            wea_q    <= '0;
            cea_q    <= 1'b0;
            is_rd_q  <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dia_q    <= dia_d;
            wea_q    <= wea_d;
            cea_q    <= cea_d;
            is_rd_q  <= is_rd_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dia_d    = dia_q;
        wea_d    = wea_q;
        cea_d    = 1'b0;
        is_rd_d  = is_rd_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel) begin
                    addr_d  = bus.mem_addr[11:2];
                    dia_d   = bus.mem_wdata;
                    wea_d   = bus.mem_wstrb;
                    cea_d   = 1'b1;
                    is_rd_d = (bus.mem_wstrb == 4'b0000);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // RAM samples cea/wea on this edge; drop them so cea is a single-cycle strobe
                wea_d = 4'b0000;
                if (is_rd_q) begin
                    state_d = CAPTURE;
                end else begin
                    ready_d = 1'b1;
                    if (wr_cnt_q != {CNT_W{1'b1}})
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    state_d = DONE;
                end
            end
            CAPTURE: begin
                rdata_d = bram_doa;
                ready_d = 1'b1;
                if (rd_cnt_q != {CNT_W{1'b1}})
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bram_addra    = addr_q;
    assign bram_cea      = cea_q;
    assign bram_dia      = dia_q;
    assign bram_wea      = wea_q;
    assign bram_rsta     = rsta;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_bram_mem_bridge.sv
// Scoreboard bench for bram_mem_bridge with a behavioural BRAM and shadow memory.
// Small counter width so saturation is reachable in a short run.
module tb_bram_mem_bridge;

    localparam logic [31:0] BASE = 32'h8000_2000;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct {
        bit          rd;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rsta = 1'b1;
    logic          sel;
    logic [9:0]    bram_addra;
    logic          bram_cea;
    logic [31:0]   bram_dia;
    logic [3:0]    bram_wea;
    logic          bram_rsta;
    logic [31:0]   bram_doa = '0;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;

    logic [31:0] ram    [1024];
    logic [31:0] shadow [1024];
    exp_t        sb[$];

    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic [31:0] last_rd = '0;
    logic        rdy_prev = 1'b0;
    logic        cea_prev = 1'b0;

    bram_mem_bridge_if bus ();

    bram_mem_bridge #(
        .BASE_ADDR(BASE),
        .CNT_W    (CW)
    ) dut (
        .clka      (clk),
        .rsta      (rsta),
        .bus       (bus),
        .sel       (sel),
        .bram_addra(bram_addra),
        .bram_cea  (bram_cea),
        .bram_dia  (bram_dia),
        .bram_wea  (bram_wea),
        .bram_rsta (bram_rsta),
        .bram_doa  (bram_doa),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // read-first single-port RAM, output valid after the enabled edge
    always @(posedge clk) begin
        if (bram_rsta) begin
            bram_doa <= '0;
        end else if (bram_cea) begin
            bram_doa <= ram[bram_addra];
            for (int b = 0; b < 4; b++)
                if (bram_wea[b])
                    ram[bram_addra][8*b +: 8] <= bram_dia[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsta) last_rd = '0;
        if (rdy_prev) check("rdy_pulse", 32'(bus.mem_ready), 0);
        if (cea_prev) check("cea_run", 32'(bram_cea), 0);
        if (bus.mem_ready) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 32'(bus.mem_ready), 0);
            end else begin
                e = sb.pop_front();
                check("ack_cycle", cyc, e.cyc);
                if (e.rd) begin
                    check("rdata", bus.mem_rdata, e.d);
                    last_rd = e.d;
                end else begin
                    check("rdata_hold", bus.mem_rdata, last_rd);
                end
            end
        end
        rdy_prev = bus.mem_ready;
        cea_prev = bram_cea;
    end

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        exp_t e;
        @(negedge clk);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        bus.mem_valid = 1'b1;
        e.rd = (s == 4'b0000);
        if (e.rd) begin
            e.d   = shadow[a[11:2]];
            e.cyc = cyc + 3;
            exp_rd++;
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) shadow[a[11:2]][8*b +: 8] = d[8*b +: 8];
            e.d   = '0;
            e.cyc = cyc + 2;
            exp_wr++;
        end
        sb.push_back(e);
        #1;
        check("sel_hit", 32'(sel), 1);
    endtask

    task automatic finish_req();
        bit got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = bus.mem_ready;
        end
        check("ack_seen", 32'(got), 1);
        bus.mem_valid = 1'b0;
        check("rd_count", 32'(rd_count), sat(exp_rd));
        check("wr_count", 32'(wr_count), sat(exp_wr));
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        start(a, d, s);
        finish_req();
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(negedge clk);
        rsta = 1'b0;
        check("rst_ready", 32'(bus.mem_ready), 0);
        check("rst_rdata", bus.mem_rdata, 0);
        check("rst_addra", 32'(bram_addra), 0);
        check("rst_cea", 32'(bram_cea), 0);
        check("rst_dia", bram_dia, 0);
        check("rst_wea", 32'(bram_wea), 0);
        check("rst_rdcnt", 32'(rd_count), 0);
        check("rst_wrcnt", 32'(wr_count), 0);

        start(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        check("wr_addra", 32'(bram_addra), 4);
        check("wr_wea", 32'(bram_wea), 32'hF);
        check("wr_cea", 32'(bram_cea), 1);
        finish_req();
        check("wr_wea_off", 32'(bram_wea), 0);
        check("wr_cea_off", 32'(bram_cea), 0);

        xfer(BASE + 32'h10, 32'h0, 4'h0);
        xfer(BASE + 32'h10, 32'h0000_00AA, 4'b0001);
        xfer(BASE + 32'h13, 32'h0, 4'h0);

        @(negedge clk);
        bus.mem_addr  = BASE + 32'h1000;
        bus.mem_wstrb = 4'hF;
        bus.mem_valid = 1'b1;
        #1;
        check("oow_sel", 32'(sel), 0);
        repeat (5) begin
            @(negedge clk);
            check("oow_cea", 32'(bram_cea), 0);
        end
        check("oow_rdcnt", 32'(rd_count), sat(exp_rd));
        check("oow_wrcnt", 32'(wr_count), sat(exp_wr));
        bus.mem_valid = 1'b0;

        @(negedge clk);
        bus.mem_addr  = BASE + 32'h10;
        bus.mem_wstrb = 4'h0;
        bus.mem_valid = 1'b1;
        for (int k = 0; k < 3; k++)
            sb.push_back('{1'b1, shadow[4], cyc + 3 + 4*k});
        exp_rd += 3;
        n = 0;
        for (int i = 0; i < 16 && n < 3; i++) begin
            @(negedge clk);
            if (bus.mem_ready) n++;
        end
        bus.mem_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_pulses", n, 3);
        check("b2b_rdcnt", 32'(rd_count), sat(exp_rd));

        for (int i = 0; i < 10; i++) begin
            a = BASE + 32'($urandom_range(0, 15) * 4);
            s = 4'($urandom_range(1, 15));
            xfer(a, $urandom, s);
            xfer(a, 32'h0, 4'h0);
        end

        for (int i = 0; i < 6; i++)
            xfer(BASE + 32'($urandom_range(16, 31) * 4), $urandom, 4'hF);
        check("sat_wr", 32'(wr_count), CMAX);
        check("sat_rd", 32'(rd_count), CMAX);

        start(BASE + 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rsta = 1'b1;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        rsta = 1'b0;
        sb.delete();
        exp_rd = 0;
        exp_wr = 0;
        check("abort_ready", 32'(bus.mem_ready), 0);
        check("abort_rdata", bus.mem_rdata, 0);
        check("abort_cea", 32'(bram_cea), 0);
        check("abort_rdcnt", 32'(rd_count), 0);
        repeat (3) @(negedge clk);
        xfer(BASE + 32'h10, 32'h0, 4'h0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
